// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, imem req/ack, 2-entry fetch queue
// imem_req/imem_addr are registered, so a request is visible the cycle after it is decided.
module instr_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready
);

    logic [ADDR_W-1:0] fetch_pc;
    logic [1:0]        count;
    logic              discard;
    logic [DATA_W-1:0] q0_instr, q1_instr;
    logic [ADDR_W-1:0] q0_pc, q1_pc;

    logic              ack_v;
    logic              push;
    logic              pop;
    logic              wr_hi;
    logic [1:0]        count_n;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic              discard_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;

    assign if_valid = (count != 2'd0);
    assign if_instr = q0_instr;
    assign if_pc    = q0_pc;

    assign ack_v = imem_ack && imem_req;
    assign push  = ack_v && !discard && !redirect;
    assign pop   = if_valid && if_ready && !redirect;
    // After a pop the surviving entry sits in slot 0, so the push lands behind it.
    assign wr_hi = (count == 2'd2 && pop) || (count == 2'd1 && !pop);

    always_comb begin
        count_n    = count + {1'b0, push} - {1'b0, pop};
        fetch_pc_n = fetch_pc;
        discard_n  = discard;
        if (redirect) begin
            count_n    = 2'd0;
            fetch_pc_n = {redirect_pc[ADDR_W-1:2], 2'b00};
            discard_n  = imem_req && !imem_ack;
        end else begin
            if (push)
                fetch_pc_n = fetch_pc + ADDR_W'(4);
            if (ack_v)
                discard_n = 1'b0;
        end
    end

    // An outstanding request is frozen until acked; a new one needs a guaranteed slot.
    always_comb begin
        req_n  = 1'b0;
        addr_n = imem_addr;
        if (imem_req && !imem_ack) begin
            req_n = 1'b1;
        end else if (count_n <= 2'd1) begin
            req_n  = 1'b1;
            addr_n = fetch_pc_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= PC_RESET;
            count     <= 2'd0;
            discard   <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= PC_RESET;
            q0_instr  <= '0;
            q1_instr  <= '0;
            q0_pc     <= '0;
            q1_pc     <= '0;
        end else begin
            fetch_pc  <= fetch_pc_n;
            count     <= count_n;
            discard   <= discard_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            if (pop) begin
                q0_instr <= q1_instr;
                q0_pc    <= q1_pc;
            end
            if (push) begin
                if (wr_hi) begin
                    q1_instr <= imem_rdata;
                    q1_pc    <= imem_addr;
                end else begin
                    q0_instr <= imem_rdata;
                    q0_pc    <= imem_addr;
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting between the program counter and instruction memory. It holds the fetch PC, issues read requests to instruction memory over a req/ack handshake, buffers returned words with their PCs in a 2-entry queue, and hands them to decode over a valid/ready handshake. Branch/jump redirects flush the queue and any in-flight read.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- PC_RESET, 0, fetch PC after reset
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  one-cycle pulse: discard everything and fetch from redirect_pc
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  read request, held until imem_ack
- imem_addr  out  ADDR_W  read address, stable while imem_req high
- imem_ack  in  1  read complete this cycle; imem_rdata valid
- imem_rdata  in  DATA_W  instruction word
- if_valid  out  1  head of queue valid
- if_instr  out  DATA_W  head instruction
- if_pc  out  ADDR_W  PC of head instruction
- if_ready  in  1  decode accepts head when if_valid high

## Operation
- Registers: fetch_pc, 2-entry queue {instr, pc} with occupancy count 0..2, in-flight bit, discard bit.
- Request issue: imem_req asserted in a cycle if in-flight already set, or occupancy (start of cycle, after this cycle's pop not counted) ≤ 1. Once asserted, imem_req and imem_addr stay unchanged until the imem_ack cycle, regardless of pops or redirects.
- imem_addr = fetch_pc of the request.
- On imem_ack with discard clear and no redirect: push {imem_rdata, imem_addr}; fetch_pc += 4 (wraps modulo 2^ADDR_W).
- On imem_ack with discard set: data dropped; discard clears; fetch_pc unchanged.
- Pop: if_valid && if_ready removes head; push and pop in same cycle legal at any occupancy 1..2 (count unchanged).
- Queue never overflows: a request is only launched when a slot is guaranteed.
- Redirect (priority over push and pop): queue flushed (count 0); fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}; if a request is in flight and not acked this cycle, discard set; if acked this cycle, its data dropped. Any pop that cycle is void.
- Redirect while discard already set: fetch_pc takes the newest redirect_pc; discard stays set.
- imem_ack without imem_req: ignored.

## Timing
- Reset values: imem_req 0, imem_addr PC_RESET, if_valid 0, if_instr 0, if_pc 0, fetch_pc PC_RESET, count 0, in-flight 0, discard 0.
- First cycle after rst deasserts: imem_req = 1, imem_addr = PC_RESET.
- imem_ack is sampled combinationally; ack may arrive in the request's first cycle (zero wait) or any later cycle.
- Ack at cycle N (valid push) → if_valid = 1 with that word at cycle N+1; new request (addr+4) may be high at cycle N+1.
- Zero-wait memory with if_ready held 1: one instruction per cycle sustained.
- if_ready held 0: after 2 pushes imem_req drops (no in-flight); reasserts the cycle after a pop.
- Redirect at cycle N with no in-flight: imem_req = 1, imem_addr = redirect_pc at N+1; if_valid = 0 at N+1.
- Redirect during in-flight: old address held until its ack; redirect address requested the cycle after that ack.
- rst asserted mid-operation: all outputs return to reset values immediately (asynchronous); any outstanding memory transaction is abandoned.

## Test plan
- Reset, zero-wait ack, if_ready=1 → imem_addr 0x0,0x4,0x8,... on consecutive cycles; if_pc/if_instr follow one cycle later, one per cycle.
- Ack latency 3 cycles each → imem_addr stable for 3 cycles per request; if_valid pulses once per fetch with matching if_pc.
- if_ready=0, zero-wait → two words queued (0x0, 0x4), imem_req low from cycle 3; raise if_ready → pops 0x0, 0x4, fetching resumes at 0x8 with no gaps or duplicates.
- Redirect to 0x100 while 0x8 in flight (ack 2 cycles later) → 0x8 data dropped, queue flushed, next imem_addr 0x100, first if_pc 0x100.
- Redirect to 0x203 coinciding with ack and pop → acked word dropped, pop void, next imem_addr 0x200.
- fetch_pc = 0xFFFFFFFC, ack → next imem_addr 0x0; assert rst while imem_req high → imem_req and if_valid 0 immediately, restart at PC_RESET.
